// File: rtl/floating_point_accum_tlast_checker.sv
// floating_point_accum_tlast_checker
// Receive-side checker for the floating-point accumulator demo. It accepts
// result beats on an AXI-Stream sink and compares each beat's tlast against
// the compile-time boundary mask LAST_MASK. It reports beat, packet and error
// counts, the data of the latest tlast beat, and a pass/fail verdict.
//
// Optional feature macro: ACCUM_CHK_BACKPRESSURE_EN
//   When defined, a 2-bit throttle counter drops tready one RUN cycle in four
//   so that upstream stall handling gets exercised.
//   When undefined, tready is high for the whole run.

module floating_point_accum_tlast_checker #(
  parameter int          DATA_W    = 32,
  parameter int          NUM_BEATS = 10,
  parameter logic [15:0] LAST_MASK = 16'h0280
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic              s_axis_tlast,
  output logic [3:0]        beat_cnt,
  output logic [3:0]        pkt_cnt,
  output logic [7:0]        err_cnt,
  output logic [DATA_W-1:0] last_data,
  output logic              busy,
  output logic              done,
  output logic              pass
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] LAST_IDX = 4'(NUM_BEATS - 1);

  state_t     state;
  state_t     state_next;
  logic       accept;
  logic       expected_last;
  logic       mismatch;
  logic       final_beat;
  logic       run_start;
  logic [7:0] err_next;

`ifdef ACCUM_CHK_BACKPRESSURE_EN
  logic [1:0] throttle;

  // Throttle counter: cleared when a run starts, counts every RUN cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      throttle <= 2'd0;
    end else if (run_start) begin
      throttle <= 2'd0;
    end else if (state == RUN) begin
      throttle <= throttle + 2'd1;
    end
  end

  assign s_axis_tready = (state == RUN) && (throttle != 2'b11);
`else
  assign s_axis_tready = (state == RUN);
`endif

  assign busy          = (state == RUN);
  assign accept        = s_axis_tvalid & s_axis_tready;
  assign run_start     = start && (state != RUN);
  assign expected_last = LAST_MASK[beat_cnt];
  assign mismatch      = (s_axis_tlast != expected_last);
  assign final_beat    = (beat_cnt == LAST_IDX);
  // The error count after this beat, so the final verdict includes the last
  // beat's comparison even though err_cnt itself only updates on the edge.
  assign err_next      = (mismatch && (err_cnt != 8'hFF)) ? err_cnt + 8'd1 : err_cnt;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode: start launches a run, the final accepted beat ends it.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) state_next = RUN;
      end
      RUN: begin
        if (accept && final_beat) state_next = DONE;
      end
      DONE: begin
        if (start) state_next = RUN;
      end
      default: state_next = IDLE;
    endcase
  end

  // Counters, captured data and verdict; held in DONE until the next start.
  always_ff @(posedge clk) begin
    if (rst) begin
      beat_cnt  <= 4'd0;
      pkt_cnt   <= 4'd0;
      err_cnt   <= 8'd0;
      last_data <= '0;
      done      <= 1'b0;
      pass      <= 1'b0;
    end else if (run_start) begin
      beat_cnt  <= 4'd0;
      pkt_cnt   <= 4'd0;
      err_cnt   <= 8'd0;
      last_data <= '0;
      done      <= 1'b0;
      pass      <= 1'b0;
    end else if ((state == RUN) && accept) begin
      err_cnt  <= err_next;
      beat_cnt <= beat_cnt + 4'd1;
      if (s_axis_tlast) begin
        pkt_cnt   <= pkt_cnt + 4'd1;
        last_data <= s_axis_tdata;
      end
      if (final_beat) begin
        done <= 1'b1;
        pass <= (err_next == 8'd0);
      end
    end
  end

endmodule

// File: tb/tb_floating_point_accum_tlast_checker.sv
// Testbench for floating_point_accum_tlast_checker.
// Directed runs push their hand-computed end-of-run results into a queue;
// a monitor pops and compares them whenever done rises.

module tb_floating_point_accum_tlast_checker;

  logic        clk;
  logic        rst;
  logic        start;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic [31:0] s_axis_tdata;
  logic        s_axis_tlast;
  logic [3:0]  beat_cnt;
  logic [3:0]  pkt_cnt;
  logic [7:0]  err_cnt;
  logic [31:0] last_data;
  logic        busy;
  logic        done;
  logic        pass;

  typedef struct {
    logic [3:0]  beats;
    logic [3:0]  pkts;
    logic [7:0]  errs;
    logic [31:0] data;
    logic        pass;
  } exp_t;

  exp_t exp_q[$];
  int   total;
  int   bad;
  int   cyc;
  logic done_q;

  floating_point_accum_tlast_checker #(
    .DATA_W(32),
    .NUM_BEATS(10),
    .LAST_MASK(16'h0280)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready),
    .s_axis_tdata(s_axis_tdata),
    .s_axis_tlast(s_axis_tlast),
    .beat_cnt(beat_cnt),
    .pkt_cnt(pkt_cnt),
    .err_cnt(err_cnt),
    .last_data(last_data),
    .busy(busy),
    .done(done),
    .pass(pass)
  );

  // 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Free-running cycle counter for run-length measurement.
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: on each rising done, pop the expected run result and compare.
  initial done_q = 1'b0;
  always @(negedge clk) begin
    if (done && !done_q) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_done", 32'(exp_q.size()), 32'd1);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        checkOutput("beat_cnt", 32'(beat_cnt), 32'(e.beats));
        checkOutput("pkt_cnt", 32'(pkt_cnt), 32'(e.pkts));
        checkOutput("err_cnt", 32'(err_cnt), 32'(e.errs));
        checkOutput("last_data", last_data, e.data);
        checkOutput("pass", 32'(pass), 32'(e.pass));
        checkOutput("busy_in_done", 32'(busy), 32'd0);
      end
    end
    done_q <= done;
  end

  function automatic exp_t mk(input int beats, input int pkts, input int errs,
                              input int data, input bit p);
    exp_t e;
    e.beats = 4'(beats);
    e.pkts  = 4'(pkts);
    e.errs  = 8'(errs);
    e.data  = 32'(data);
    e.pass  = p;
    return e;
  endfunction

  // Offer one beat and hold it until accepted (bounded).
  task automatic applyStimulus(input logic [31:0] data, input logic last);
    logic accepted;
    int   n;
    accepted      = 1'b0;
    n             = 0;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = data;
    s_axis_tlast  = last;
    while (!accepted && n < 20) begin
      accepted = s_axis_tready;
      @(posedge clk);
      #1;
      n++;
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    checkOutput("accept_timeout", 32'(accepted), 32'd1);
  endtask

  task automatic pulseStart();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic waitDone();
    int n;
    n = 0;
    while (!done && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("done_timeout", 32'(done), 32'd1);
    @(posedge clk);
    #1;
  endtask

  // Full run: tlast follows pattern, tdata = beat index, optional gaps and
  // an ignored start pulse after beat 3.
  task automatic runBeats(input logic [9:0] pattern, input int gap, input bit mid_start);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(32'(i), pattern[i]);
      if (mid_start && i == 3) pulseStart();
      for (int g = 0; g < gap; g++) begin
        @(posedge clk);
        #1;
      end
    end
    waitDone();
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_beat"}, 32'(beat_cnt), 32'd0);
    checkOutput({tag, "_pkt"}, 32'(pkt_cnt), 32'd0);
    checkOutput({tag, "_err"}, 32'(err_cnt), 32'd0);
    checkOutput({tag, "_data"}, last_data, 32'd0);
    checkOutput({tag, "_done"}, 32'(done), 32'd0);
    checkOutput({tag, "_pass"}, 32'(pass), 32'd0);
  endtask

  initial begin
    int t0;
    total         = 0;
    bad           = 0;
    rst           = 1'b1;
    start         = 1'b0;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = 32'd0;
    s_axis_tlast  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state.
    checkAllZero("reset");
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_tready", 32'(s_axis_tready), 32'd0);

    // Beats offered in IDLE are not consumed.
    s_axis_tvalid = 1'b1;
    s_axis_tlast  = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    checkOutput("idle_beat", 32'(beat_cnt), 32'd0);

    // Clean run.
    exp_q.push_back(mk(10, 2, 0, 9, 1'b1));
    pulseStart();
    checkOutput("start_busy", 32'(busy), 32'd1);
    checkOutput("start_tready", 32'(s_axis_tready), 32'd1);
    runBeats(10'h280, 0, 1'b0);

    // tlast early at beat 3, missing at beat 7.
    exp_q.push_back(mk(10, 2, 2, 9, 1'b0));
    pulseStart();
    runBeats(10'h208, 0, 1'b0);

    // Every tlast wrong: packets on 0..6 and 8, so last_data comes from beat 8.
    exp_q.push_back(mk(10, 8, 10, 8, 1'b0));
    pulseStart();
    runBeats(10'h17F, 0, 1'b0);

    // Gapped valid.
    exp_q.push_back(mk(10, 2, 0, 9, 1'b1));
    pulseStart();
    runBeats(10'h280, 3, 1'b0);

    // Reset mid-run after 5 beats.
    pulseStart();
    for (int i = 0; i < 5; i++) applyStimulus(32'(i), 1'b0);
    checkOutput("mid_beat", 32'(beat_cnt), 32'd5);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkAllZero("midrst");
    checkOutput("midrst_busy", 32'(busy), 32'd0);
    checkOutput("midrst_tready", 32'(s_axis_tready), 32'd0);

    // Clean run after reset, with an ignored start pulse during RUN.
    exp_q.push_back(mk(10, 2, 0, 9, 1'b1));
    pulseStart();
    runBeats(10'h280, 0, 1'b1);

    // Start in DONE clears everything and a second clean run passes.
    checkOutput("held_done", 32'(done), 32'd1);
    checkOutput("held_beat", 32'(beat_cnt), 32'd10);
    exp_q.push_back(mk(10, 2, 0, 9, 1'b1));
    t0 = cyc;
    pulseStart();
    checkAllZero("restart");
    checkOutput("restart_busy", 32'(busy), 32'd1);
    runBeats(10'h280, 0, 1'b0);
`ifdef ACCUM_CHK_BACKPRESSURE_EN
    checkOutput("bp_run_cycles", 32'((cyc - t0) >= 15), 32'd1);
`else
    checkOutput("run_cycles", 32'(cyc - t0), 32'd12);
`endif

    checkOutput("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
